// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register of the 5-stage core.
//
// Latches the MEM-stage result and extracts load data from the raw memory
// word (big-endian byte lanes, sign/zero extension, alignment check). It
// drives the regfile write port, owns the architectural HI/LO registers and
// exports the WB-stage write for forwarding.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   stall_mem, stall_wb pipeline stall controls
//   flush               squash the instruction entering WB
//   mem_*               MEM-stage result, load control and HI/LO write
//   wb_we/waddr/wdata   regfile write port (also forwarded to EX/ID)
//   wb_whilo/hi/lo      HI/LO write pending in WB
//   hi_o, lo_o          current HI/LO with the pending WB write bypassed
//   wb_misalign         load in WB was misaligned
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_mem,
    input  logic          stall_wb,
    input  logic          flush,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic [2:0]    mem_ld_op,
    input  logic [1:0]    mem_addr_lo,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_whilo,
    input  logic [DW-1:0] mem_hi,
    input  logic [DW-1:0] mem_lo,
    output logic          wb_we,
    output logic [AW-1:0] wb_waddr,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_whilo,
    output logic [DW-1:0] wb_hi,
    output logic [DW-1:0] wb_lo,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          wb_misalign
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LW  = 3'd5;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;
    logic          ld_misalign;
    logic [DW-1:0] hi_r;
    logic [DW-1:0] lo_r;
    logic          bubble;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        ld_byte = mem_rdata[31:24];
        case (mem_addr_lo)
            2'd0:    ld_byte = mem_rdata[31:24];
            2'd1:    ld_byte = mem_rdata[23:16];
            2'd2:    ld_byte = mem_rdata[15:8];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end

    always_comb begin
        ld_data     = mem_wdata;
        ld_misalign = 1'b0;
        case (mem_ld_op)
            LD_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU: ld_data = {24'd0, ld_byte};
            LD_LH: begin
                ld_data     = {{16{ld_half[15]}}, ld_half};
                ld_misalign = mem_addr_lo[0];
            end
            LD_LHU: begin
                ld_data     = {16'd0, ld_half};
                ld_misalign = mem_addr_lo[0];
            end
            LD_LW: begin
                ld_data     = mem_rdata;
                ld_misalign = (mem_addr_lo != 2'd0);
            end
            default: ld_data = mem_wdata;
        endcase
        if (ld_misalign) begin
            ld_data = '0;
        end
    end

    // A stalled MEM with a free WB must not let its instruction advance twice,
    // so WB receives a bubble.
    assign bubble = flush || (stall_mem && !stall_wb);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_we       <= 1'b0;
            wb_waddr    <= '0;
            wb_wdata    <= '0;
            wb_whilo    <= 1'b0;
            wb_hi       <= '0;
            wb_lo       <= '0;
            wb_misalign <= 1'b0;
        end else if (bubble) begin
            wb_we       <= 1'b0;
            wb_waddr    <= '0;
            wb_wdata    <= '0;
            wb_whilo    <= 1'b0;
            wb_hi       <= '0;
            wb_lo       <= '0;
            wb_misalign <= 1'b0;
        end else if (!(stall_mem && stall_wb)) begin
            // Writes to r0 are dropped but the address is kept for visibility.
            wb_we       <= mem_we && !ld_misalign && (mem_waddr != '0);
            wb_waddr    <= mem_waddr;
            wb_wdata    <= ld_data;
            wb_whilo    <= mem_whilo;
            wb_hi       <= mem_hi;
            wb_lo       <= mem_lo;
            wb_misalign <= ld_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (wb_whilo && !stall_wb) begin
            hi_r <= wb_hi;
            lo_r <= wb_lo;
        end
    end

    assign hi_o = wb_whilo ? wb_hi : hi_r;
    assign lo_o = wb_whilo ? wb_lo : lo_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem, stall_wb, flush;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ld_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo, hi_o, lo_o;
    logic        wb_misalign;

    int total = 0;
    int bad   = 0;

    mem_wb_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush(flush), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_ld_op(mem_ld_op), .mem_addr_lo(mem_addr_lo),
        .mem_rdata(mem_rdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .hi_o(hi_o),
        .lo_o(lo_o), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic mis);
        chk({tag, ".we"}, {31'd0, wb_we}, {31'd0, we});
        chk({tag, ".waddr"}, {27'd0, wb_waddr}, {27'd0, wa});
        chk({tag, ".wdata"}, wb_wdata, wd);
        chk({tag, ".misalign"}, {31'd0, wb_misalign}, {31'd0, mis});
    endtask

    task automatic load(input string tag, input logic [2:0] op, input logic [1:0] a,
                        input logic [31:0] exp);
        mem_ld_op   = op;
        mem_addr_lo = a;
        step();
        chk_wb(tag, 1'b1, 5'd5, exp, 1'b0);
    endtask

    initial begin
        rst = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
        mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h11;
        mem_ld_op = 3'd0; mem_addr_lo = 2'd0; mem_rdata = 32'h0;
        mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;

        // Reset held for two edges.
        step();
        step();
        chk_wb("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("reset.whilo", {31'd0, wb_whilo}, 32'd0);
        chk("reset.hi_o", hi_o, 32'h0);
        chk("reset.lo_o", lo_o, 32'h0);
        rst = 1'b1;
        step();
        chk_wb("post_reset", 1'b1, 5'd3, 32'h11, 1'b0);

        // Load extraction.
        mem_waddr = 5'd5;
        mem_rdata = 32'h8421F0A5;
        load("lb0",  3'd1, 2'd0, 32'hFFFFFF84);
        load("lbu3", 3'd2, 2'd3, 32'h000000A5);
        load("lb1",  3'd1, 2'd1, 32'h00000021);
        load("lh2",  3'd3, 2'd2, 32'hFFFFF0A5);
        load("lhu0", 3'd4, 2'd0, 32'h00008421);
        load("lw",   3'd5, 2'd0, 32'h8421F0A5);
        mem_ld_op = 3'd7; mem_wdata = 32'h77;
        step();
        chk_wb("op7", 1'b1, 5'd5, 32'h77, 1'b0);

        // Misaligned loads: flagged for a single cycle.
        mem_ld_op = 3'd5; mem_addr_lo = 2'd1;
        step();
        chk_wb("lw_mis", 1'b0, 5'd5, 32'h0, 1'b1);
        mem_ld_op = 3'd0; mem_wdata = 32'h55;
        step();
        chk_wb("lw_mis_after", 1'b1, 5'd5, 32'h55, 1'b0);
        mem_ld_op = 3'd3; mem_addr_lo = 2'd3;
        step();
        chk_wb("lh_mis", 1'b0, 5'd5, 32'h0, 1'b1);
        mem_ld_op = 3'd0;
        step();
        chk_wb("lh_mis_after", 1'b1, 5'd5, 32'h55, 1'b0);

        // Misalign held while WB is stalled.
        mem_ld_op = 3'd5; mem_addr_lo = 2'd2;
        step();
        chk_wb("lw2_mis", 1'b0, 5'd5, 32'h0, 1'b1);
        stall_mem = 1'b1; stall_wb = 1'b1;
        step();
        chk_wb("lw2_mis_held", 1'b0, 5'd5, 32'h0, 1'b1);
        stall_mem = 1'b0; stall_wb = 1'b0; mem_ld_op = 3'd0;
        step();
        chk_wb("lw2_mis_after", 1'b1, 5'd5, 32'h55, 1'b0);

        // Hold under full stall, then flush during stall.
        mem_waddr = 5'd7; mem_wdata = 32'h12345678;
        step();
        chk_wb("pre_hold", 1'b1, 5'd7, 32'h12345678, 1'b0);
        stall_mem = 1'b1; stall_wb = 1'b1;
        mem_waddr = 5'd9; mem_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_wb("hold", 1'b1, 5'd7, 32'h12345678, 1'b0);
        end
        flush = 1'b1;
        step();
        chk_wb("flush_stall", 1'b0, 5'd0, 32'h0, 1'b0);
        flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0; mem_wdata = 32'h99;
        step();
        chk_wb("relatch", 1'b1, 5'd9, 32'h99, 1'b0);
        stall_mem = 1'b1;
        step();
        chk_wb("mem_stall_bubble", 1'b0, 5'd0, 32'h0, 1'b0);
        stall_mem = 1'b0;

        // HI/LO bypass then commit.
        mem_we = 1'b0; mem_whilo = 1'b1;
        mem_hi = 32'hAAAA0000; mem_lo = 32'h0000BBBB;
        step();
        chk("hilo.whilo", {31'd0, wb_whilo}, 32'd1);
        chk("hilo.bypass_hi", hi_o, 32'hAAAA0000);
        chk("hilo.bypass_lo", lo_o, 32'h0000BBBB);
        chk("hilo.we", {31'd0, wb_we}, 32'd0);
        mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;
        step();
        chk("hilo.whilo_clr", {31'd0, wb_whilo}, 32'd0);
        chk("hilo.commit_hi", hi_o, 32'hAAAA0000);
        chk("hilo.commit_lo", lo_o, 32'h0000BBBB);

        // Back-to-back HI/LO writes: the later one must end up architectural.
        mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
        step();
        chk("b2b.first_hi", hi_o, 32'h1);
        mem_hi = 32'h3; mem_lo = 32'h4;
        step();
        chk("b2b.second_hi", hi_o, 32'h3);
        mem_whilo = 1'b0;
        step();
        chk("b2b.final_hi", hi_o, 32'h3);
        chk("b2b.final_lo", lo_o, 32'h4);

        // r0 write suppressed, address and data still latched.
        mem_we = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'hDEADBEEF;
        step();
        chk_wb("r0", 1'b0, 5'd0, 32'hDEADBEEF, 1'b0);

        // GPR write and HI/LO write together.
        mem_waddr = 5'd4; mem_wdata = 32'h44; mem_whilo = 1'b1;
        mem_hi = 32'h5; mem_lo = 32'h6;
        step();
        chk_wb("we_whilo", 1'b1, 5'd4, 32'h44, 1'b0);
        chk("we_whilo.hi_o", hi_o, 32'h5);
        chk("we_whilo.lo_o", lo_o, 32'h6);

        // Reset during a full stall discards everything, including HI/LO.
        stall_mem = 1'b1; stall_wb = 1'b1; rst = 1'b0;
        step();
        chk_wb("rst_stall", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst_stall.whilo", {31'd0, wb_whilo}, 32'd0);
        chk("rst_stall.hi_o", hi_o, 32'h0);
        chk("rst_stall.lo_o", lo_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the 5-stage core.
- Latches MEM-stage results and performs load-data extraction, sign/zero extension and alignment checking.
- Drives the regfile write port (we/waddr/wdata) and owns the architectural HI/LO registers.
- Also exports the WB-stage write for EX/ID forwarding.

Parameters:
- DW, 32, datapath width (fixed at 32; byte-lane logic assumes 4 lanes)
- AW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- stall_mem  in  1  MEM stage stalled this cycle
- stall_wb  in  1  WB stage stalled this cycle
- flush  in  1  squash the instruction entering WB
- mem_we  in  1  MEM instruction writes a GPR
- mem_waddr  in  5  destination GPR
- mem_wdata  in  32  non-load result
- mem_ld_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6/7 treated as none
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_rdata  in  32  raw data-memory word
- mem_whilo  in  1  MEM instruction writes HI/LO
- mem_hi  in  32  HI value
- mem_lo  in  32  LO value
- wb_we  out  1  regfile write enable
- wb_waddr  out  5  regfile write address
- wb_wdata  out  32  regfile write data
- wb_whilo  out  1  HI/LO write pending in WB
- wb_hi  out  32  pending HI value
- wb_lo  out  32  pending LO value
- hi_o  out  32  current HI, bypassed
- lo_o  out  32  current LO, bypassed
- wb_misalign  out  1  one-cycle flag: load in WB was misaligned

Behaviour:
- All state updates on posedge clk only.
- Reset (rst=0 at edge):
  - wb_we=0, wb_waddr=0, wb_wdata=0
  - wb_whilo=0, wb_hi=0, wb_lo=0, wb_misalign=0
  - HI/LO registers = 0
  - Reset mid-stall discards held contents.
- Stage-register update priority, per edge:
  1. reset
  2. flush → bubble: wb_we=0, wb_whilo=0, wb_misalign=0; addr/data fields cleared to 0
  3. stall_mem=1 and stall_wb=0 → bubble, same as flush
  4. stall_mem=1 and stall_wb=1 → hold all stage registers
  5. otherwise → latch MEM inputs
- Latency: one cycle from MEM inputs to wb_* outputs. There are no combinational paths from MEM inputs to wb_* outputs.
- Load extraction (big-endian; lane k = byte at offset k = bits [31-8k:24-8k]):
  - LB/LBU: byte at addr_lo; sign- or zero-extended
  - LH/LHU: halfword at addr_lo (0 → [31:16], 2 → [15:0]); sign- or zero-extended
  - LW: whole word
  - ld_op=none: wb_wdata = mem_wdata
- Misalignment:
  - Condition: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
  - Latched result: wb_we=0, wb_wdata=0, wb_misalign=1.
  - wb_misalign is asserted only for the cycle(s) that instruction occupies WB; held if WB is stalled.
- r0 writes: wb_we is forced to 0 when the latched waddr = 0. waddr is still latched.
- HI/LO:
  - At each edge where wb_whilo=1 and stall_wb=0, HI←wb_hi and LO←wb_lo.
  - hi_o = wb_whilo ? wb_hi : HI. lo_o likewise (combinational bypass).
  - Back-to-back whilo instructions: each commits in order, with no lost update.
- mem_whilo with mem_we: both are independent and both take effect.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_we=1, mem_waddr=3 → all outputs 0. Release, then on the next edge wb_we=1, wb_waddr=3.
- Loads: mem_rdata=0x8421F0A5.
  - LB addr_lo=0 → 0xFFFFFF84
  - LBU addr_lo=3 → 0x000000A5
  - LH addr_lo=2 → 0xFFFFF0A5
  - LHU addr_lo=0 → 0x00008421
  - LW → 0x8421F0A5
- Misaligned: LW addr_lo=1 → wb_we=0, wb_misalign=1 for 1 cycle. LH addr_lo=3 → same.
- Stall/flush:
  - stall_mem=1, stall_wb=0 → bubble (wb_we=0).
  - Both stalls=1 for 3 cycles → outputs held (waddr=7, wdata=0x12345678).
  - flush together with both stalls → bubble.
- HI/LO:
  - mem_whilo=1, hi=0xAAAA0000, lo=0x0000BBBB → the cycle after latch, hi_o/lo_o already show the new values via bypass. One edge later, HI/LO hold them with wb_whilo=0.
  - Two consecutive whilo instructions commit in order.
- r0: mem_we=1, mem_waddr=0, mem_wdata=0xDEADBEEF → wb_we=0.
